// File: rtl/write_arb_2m1s.sv
// -----------------------------------------------------------------------------
// write_arb_2m1s
//   2:1 write-channel arbiter. Two write managers (m0, m1) share one write
//   subordinate port. One whole transaction (AW -> W burst to wlast -> B) is
//   granted at a time; the other manager sees no ready/valid until the
//   transaction completes. All ids, atop and data pass straight through with
//   no buffering and no added latency.
//
//   Compile-time option:
//     WARB_FIXED_PRIO_EN  defined   -> m0 always wins a tie (m1 can starve)
//                         undefined -> fair round-robin on ties (default)
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   mN_aw{valid,ready,id,addr,atop}   manager N write request channel
//   mN_w{valid,ready,data,strb,last}  manager N write data channel
//   mN_b{valid,ready,id,comp}         manager N write response channel
//   s_aw*/s_w*                 subordinate copies of the granted aw/w fields
//   s_awready, s_wready        subordinate channel readies
//   s_bvalid, s_bid, s_bcomp   subordinate response
//   s_bready                   response ready towards the subordinate
//   busy                       high while a transaction is granted
//   gnt                        one-hot grant (2'b00 in IDLE)
// -----------------------------------------------------------------------------
module write_arb_2m1s #(
    parameter int IDW = 4,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_awvalid,
    output logic              m0_awready,
    input  logic [IDW-1:0]    m0_awid,
    input  logic [AW-1:0]     m0_awaddr,
    input  logic [5:0]        m0_awatop,
    input  logic              m0_wvalid,
    output logic              m0_wready,
    input  logic [DW-1:0]     m0_wdata,
    input  logic [DW/8-1:0]   m0_wstrb,
    input  logic              m0_wlast,
    output logic              m0_bvalid,
    input  logic              m0_bready,
    output logic [IDW-1:0]    m0_bid,
    output logic              m0_bcomp,

    input  logic              m1_awvalid,
    output logic              m1_awready,
    input  logic [IDW-1:0]    m1_awid,
    input  logic [AW-1:0]     m1_awaddr,
    input  logic [5:0]        m1_awatop,
    input  logic              m1_wvalid,
    output logic              m1_wready,
    input  logic [DW-1:0]     m1_wdata,
    input  logic [DW/8-1:0]   m1_wstrb,
    input  logic              m1_wlast,
    output logic              m1_bvalid,
    input  logic              m1_bready,
    output logic [IDW-1:0]    m1_bid,
    output logic              m1_bcomp,

    output logic              s_awvalid,
    input  logic              s_awready,
    output logic [IDW-1:0]    s_awid,
    output logic [AW-1:0]     s_awaddr,
    output logic [5:0]        s_awatop,
    output logic              s_wvalid,
    input  logic              s_wready,
    output logic [DW-1:0]     s_wdata,
    output logic [DW/8-1:0]   s_wstrb,
    output logic              s_wlast,
    input  logic              s_bvalid,
    output logic              s_bready,
    input  logic [IDW-1:0]    s_bid,
    input  logic              s_bcomp,

    output logic              busy,
    output logic [1:0]        gnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AWR  = 2'd1,
        ST_WDT  = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [1:0]  gnt_r;
    logic [1:0]  gnt_s;
    logic [1:0]  win_s;
    logic        sel_m1_s;
    logic        aw_hs_s;
    logic        w_last_hs_s;
    logic        b_hs_s;
`ifndef WARB_FIXED_PRIO_EN
    logic        last_gnt_r;   // 1'b1 = m1 was granted last
    logic        last_gnt_s;
`endif

    assign sel_m1_s = gnt_r[1];
    assign busy     = (state_r != ST_IDLE);
    assign gnt      = gnt_r;

    // Winner selection for IDLE: a lone requester always wins; ties follow the build option.
    always_comb begin
        win_s = 2'b00;
        if (m0_awvalid && m1_awvalid) begin
`ifdef WARB_FIXED_PRIO_EN
            win_s = 2'b01;
`else
            win_s = last_gnt_r ? 2'b01 : 2'b10;
`endif
        end else if (m0_awvalid) begin
            win_s = 2'b01;
        end else if (m1_awvalid) begin
            win_s = 2'b10;
        end else begin
            win_s = 2'b00;
        end
    end

    // Channel muxes: handshake signals are gated by state and grant, payload passes through.
    always_comb begin
        s_awvalid  = 1'b0;
        s_wvalid   = 1'b0;
        s_wlast    = 1'b0;
        s_bready   = 1'b0;
        m0_awready = 1'b0;
        m1_awready = 1'b0;
        m0_wready  = 1'b0;
        m1_wready  = 1'b0;
        m0_bvalid  = 1'b0;
        m1_bvalid  = 1'b0;
        m0_bcomp   = 1'b0;
        m1_bcomp   = 1'b0;
        m0_bid     = s_bid;
        m1_bid     = s_bid;
        s_awid     = sel_m1_s ? m1_awid   : m0_awid;
        s_awaddr   = sel_m1_s ? m1_awaddr : m0_awaddr;
        s_awatop   = sel_m1_s ? m1_awatop : m0_awatop;
        s_wdata    = sel_m1_s ? m1_wdata  : m0_wdata;
        s_wstrb    = sel_m1_s ? m1_wstrb  : m0_wstrb;
        case (state_r)
            ST_AWR: begin
                s_awvalid  = sel_m1_s ? m1_awvalid : m0_awvalid;
                m0_awready = gnt_r[0] & s_awready;
                m1_awready = gnt_r[1] & s_awready;
            end
            ST_WDT: begin
                s_wvalid  = sel_m1_s ? m1_wvalid : m0_wvalid;
                s_wlast   = sel_m1_s ? m1_wlast  : m0_wlast;
                m0_wready = gnt_r[0] & s_wready;
                m1_wready = gnt_r[1] & s_wready;
            end
            ST_RSP: begin
                s_bready  = sel_m1_s ? m1_bready : m0_bready;
                m0_bvalid = gnt_r[0] & s_bvalid;
                m1_bvalid = gnt_r[1] & s_bvalid;
                m0_bcomp  = gnt_r[0] & s_bcomp;
                m1_bcomp  = gnt_r[1] & s_bcomp;
            end
            default: begin
                // IDLE: nothing is ready and stray s_bvalid is ignored.
                s_awvalid = 1'b0;
            end
        endcase
    end

    assign aw_hs_s     = s_awvalid & s_awready;
    assign w_last_hs_s = s_wvalid & s_wready & s_wlast;
    assign b_hs_s      = s_bvalid & s_bready;

    // Next-state logic: one full transaction per grant, no re-arbitration mid-transaction.
    always_comb begin
        state_s = state_r;
        gnt_s   = gnt_r;
`ifndef WARB_FIXED_PRIO_EN
        last_gnt_s = last_gnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (win_s != 2'b00) begin
                    gnt_s   = win_s;
                    state_s = ST_AWR;
                end else begin
                    gnt_s   = 2'b00;
                    state_s = ST_IDLE;
                end
            end
            ST_AWR: begin
                if (aw_hs_s) begin
                    state_s = ST_WDT;
                end else begin
                    state_s = ST_AWR;
                end
            end
            ST_WDT: begin
                if (w_last_hs_s) begin
                    state_s = ST_RSP;
                end else begin
                    state_s = ST_WDT;
                end
            end
            ST_RSP: begin
                if (b_hs_s) begin
                    state_s = ST_IDLE;
                    gnt_s   = 2'b00;
`ifndef WARB_FIXED_PRIO_EN
                    last_gnt_s = gnt_r[1];
`endif
                end else begin
                    state_s = ST_RSP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = 2'b00;
            end
        endcase
    end

    // State, grant and round-robin history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            gnt_r   <= 2'b00;
`ifndef WARB_FIXED_PRIO_EN
            last_gnt_r <= 1'b1;
`endif
        end else begin
            state_r <= state_s;
            gnt_r   <= gnt_s;
`ifndef WARB_FIXED_PRIO_EN
            last_gnt_r <= last_gnt_s;
`endif
        end
    end

endmodule

// File: tb/tb_write_arb_2m1s.sv
// Self-checking bench for write_arb_2m1s: a table of per-cycle control vectors
// followed by hand-written multi-cycle sequences (reset, data path, grant
// order, response back-pressure, asynchronous reset mid-burst).
module tb_write_arb_2m1s;

    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic clk = 1'b0;
    logic rst_n;

    logic m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_wlast, m0_bvalid, m0_bready, m0_bcomp;
    logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast, m1_bvalid, m1_bready, m1_bcomp;
    logic [IDW-1:0] m0_awid, m1_awid, m0_bid, m1_bid, s_awid, s_bid;
    logic [AW-1:0]  m0_awaddr, m1_awaddr, s_awaddr;
    logic [5:0]     m0_awatop, m1_awatop, s_awatop;
    logic [DW-1:0]  m0_wdata, m1_wdata, s_wdata;
    logic [DW/8-1:0] m0_wstrb, m1_wstrb, s_wstrb;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready, s_bcomp;
    logic busy;
    logic [1:0] gnt;

    int n_chk  = 0;
    int n_pass = 0;

    write_arb_2m1s #(.IDW(IDW), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awid(m0_awid),
        .m0_awaddr(m0_awaddr), .m0_awatop(m0_awatop),
        .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast),
        .m0_bvalid(m0_bvalid), .m0_bready(m0_bready), .m0_bid(m0_bid), .m0_bcomp(m0_bcomp),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awid(m1_awid),
        .m1_awaddr(m1_awaddr), .m1_awatop(m1_awatop),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
        .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bid(m1_bid), .m1_bcomp(m1_bcomp),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
        .s_awaddr(s_awaddr), .s_awatop(s_awatop),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bcomp(s_bcomp),
        .busy(busy), .gnt(gnt)
    );

    always #5 clk = ~clk;

    // in : {m0_awv,m1_awv, m0_wv,m1_wv, wlast, m0_br,m1_br, s_awr,s_wr,s_bv}
    // exp: {busy, gnt[1:0], s_awv,s_wv,s_br, m0_awr,m1_awr, m0_wr,m1_wr, m0_bv,m1_bv}
    typedef struct packed {
        logic [9:0]  in;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_awvalid = 1'b0; m1_awvalid = 1'b0;
        m0_wvalid  = 1'b0; m1_wvalid  = 1'b0;
        m0_wlast   = 1'b0; m1_wlast   = 1'b0;
        m0_bready  = 1'b0; m1_bready  = 1'b0;
        s_awready  = 1'b0; s_wready   = 1'b0; s_bvalid = 1'b0;
        s_bid      = 4'd0; s_bcomp    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [11:0] act;
        logic [1:0]  order [4];
        int          n_ord;

        vecs[0]  = '{10'b10_00_0_00_000, 12'b0_00_000_00_00_00};
        vecs[1]  = '{10'b10_11_1_00_000, 12'b1_01_100_00_00_00};
        vecs[2]  = '{10'b00_00_0_00_100, 12'b1_01_000_10_00_00};
        vecs[3]  = '{10'b10_00_0_00_100, 12'b1_01_100_10_00_00};
        vecs[4]  = '{10'b01_11_0_00_010, 12'b1_01_010_00_10_00};
        vecs[5]  = '{10'b00_10_1_00_000, 12'b1_01_010_00_00_00};
        vecs[6]  = '{10'b00_10_1_00_010, 12'b1_01_010_00_10_00};
        vecs[7]  = '{10'b00_00_0_00_001, 12'b1_01_000_00_00_10};
        vecs[8]  = '{10'b00_00_0_11_001, 12'b1_01_001_00_00_10};
        vecs[9]  = '{10'b01_00_0_00_001, 12'b0_00_000_00_00_00};
        vecs[10] = '{10'b11_00_0_00_100, 12'b1_10_100_01_00_00};
        vecs[11] = '{10'b00_11_1_00_010, 12'b1_10_010_00_01_00};
        vecs[12] = '{10'b00_00_0_11_001, 12'b1_10_001_00_00_01};
        vecs[13] = '{10'b00_00_0_00_000, 12'b0_00_000_00_00_00};

        m0_awid = 4'd3; m0_awaddr = 32'h0000_0100; m0_awatop = 6'h15;
        m0_wdata = 32'h0; m0_wstrb = 4'hF;
        m1_awid = 4'd5; m1_awaddr = 32'h0000_0200; m1_awatop = 6'h2A;
        m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'h3;
        clear_inputs();

        // Reset with both managers requesting and subordinate fully ready.
        rst_n = 1'b0;
        m0_awvalid = 1'b1; m1_awvalid = 1'b1;
        m0_wvalid = 1'b1; m1_wvalid = 1'b1;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1;
        m0_bready = 1'b1; m1_bready = 1'b1;
        cyc();
        cyc();
        chk("rst_readies", {m0_awready, m1_awready, m0_wready, m1_wready, m0_bvalid, m1_bvalid, s_bready}, 64'h0);
        chk("rst_valids", {s_awvalid, s_wvalid}, 64'h0);
        chk("rst_gnt", {busy, gnt}, 64'h0);
        rst_n = 1'b1;
        cyc();
        chk("first_gnt", gnt, 64'h1);

        // Table-driven per-cycle vectors.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            {m0_awvalid, m1_awvalid, m0_wvalid, m1_wvalid, m0_wlast, m0_bready, m1_bready,
             s_awready, s_wready, s_bvalid} = vecs[i].in;
            m1_wlast = m0_wlast;
            #1;
            act = {busy, gnt, s_awvalid, s_wvalid, s_bready, m0_awready, m1_awready,
                   m0_wready, m1_wready, m0_bvalid, m1_bvalid};
            if (act !== vecs[i].exp)
                $display("FAIL vec%0d: got %b expected %b", i, act, vecs[i].exp);
            n_chk++;
            if (act === vecs[i].exp) n_pass++;
            cyc();
        end

        // m0 4-beat write, payload pass-through, response back-pressure.
        do_reset();
        m0_awvalid = 1'b1; s_awready = 1'b1;
        cyc();
        #1;
        chk("aw_fields", {s_awvalid, m0_awready, s_awid, s_awaddr, s_awatop},
            {2'b11, 4'd3, 32'h0000_0100, 6'h15});
        cyc();
        m0_awvalid = 1'b0; s_awready = 1'b0;
        m0_wvalid = 1'b1; m1_wvalid = 1'b1; s_wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m0_wdata = 32'hA0 + 32'(i);
            m0_wlast = (i == 3);
            #1;
            chk($sformatf("beat%0d", i), {s_wvalid, s_wlast, s_wdata, s_wstrb, m0_wready, m1_wready},
                {1'b1, (i == 3) ? 1'b1 : 1'b0, 32'hA0 + 32'(i), 4'hF, 1'b1, 1'b0});
            cyc();
        end
        m0_wvalid = 1'b0; m1_wvalid = 1'b0; m0_wlast = 1'b0; s_wready = 1'b0;
        s_bvalid = 1'b1; s_bid = 4'd3; s_bcomp = 1'b1; m0_bready = 1'b0; m1_bready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("rsp_hold%0d", i), {busy, s_bready, m0_bvalid, m0_bid, m0_bcomp, m1_bvalid},
                {1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0});
            cyc();
        end
        m0_bready = 1'b1;
        #1;
        chk("rsp_done", {s_bready, m0_bvalid}, 64'h3);
        cyc();
        s_bvalid = 1'b0; m0_bready = 1'b0; m1_bready = 1'b0;
        chk("rsp_idle", {busy, gnt}, 64'h0);

        // Both managers request continuously with 1-beat writes.
        do_reset();
        m0_awvalid = 1'b1; m1_awvalid = 1'b1;
        m0_wvalid = 1'b1; m1_wvalid = 1'b1; m0_wlast = 1'b1; m1_wlast = 1'b1;
        m0_bready = 1'b1; m1_bready = 1'b1;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1;
        n_ord = 0;
        for (int c = 0; c < 24 && n_ord < 4; c++) begin
            cyc();
            if (s_awvalid && s_awready) begin
                order[n_ord] = gnt;
                n_ord++;
            end
        end
        chk("order_count", n_ord, 64'd4);
        for (int i = 0; i < n_ord; i++) begin
`ifdef WARB_FIXED_PRIO_EN
            chk($sformatf("order%0d", i), order[i], 64'h1);
`else
            chk($sformatf("order%0d", i), order[i], (i % 2 == 0) ? 64'h1 : 64'h2);
`endif
        end

        // Asynchronous reset after 2 of 4 beats.
        do_reset();
        m0_awvalid = 1'b1; s_awready = 1'b1;
        cyc();
        cyc();
        m0_awvalid = 1'b0; s_awready = 1'b0;
        m0_wvalid = 1'b1; s_wready = 1'b1; m0_wlast = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m0_wdata = 32'hA0 + 32'(i);
            cyc();
        end
        m0_wdata = 32'hA2;
        #1;
        chk("wdt_pre", {busy, gnt, s_wvalid}, {1'b1, 2'b01, 1'b1});
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {busy, gnt, s_wvalid, m0_wready}, 64'h0);
        cyc();
        rst_n = 1'b1;
        clear_inputs();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
